// File: rtl/jtcontra_pkg.sv
// rtl/jtcontra_pkg.sv - shared types for the gfx ROM slot responder
package jtcontra_pkg;

    localparam int ROMW = 17;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RDY = 2'd2
    } state_t;

endpackage

// File: rtl/jtcontra_romslot_cache.sv
// rtl/jtcontra_romslot_cache.sv - one-word address/data cache for one ROM requester
module jtcontra_romslot_cache
    import jtcontra_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    input  logic            we,
    input  logic [ROMW-1:0] waddr,
    input  logic [15:0]     wdata,
    input  logic            cs,
    input  logic [ROMW-1:0] addr,
    output logic            hit,
    output logic [15:0]     data
);

    logic [ROMW-1:0] caddr;
    logic [15:0]     cdata;
    logic            cvalid;

    // Clear wins over write so a fetch finishing during reset leaves no trace
    always_ff @(posedge clk) begin
        if (clr) begin
            caddr  <= '0;
            cdata  <= '0;
            cvalid <= 1'b0;
        end else if (we) begin
            caddr  <= waddr;
            cdata  <= wdata;
            cvalid <= 1'b1;
        end
    end

    assign hit  = cs & cvalid & (addr == caddr);
    assign data = cdata;

endmodule

// File: rtl/jtcontra_gfx_romslot.sv
// rtl/jtcontra_gfx_romslot.sv - two-requester gfx ROM responder sharing one SDRAM read port
module jtcontra_gfx_romslot
    import jtcontra_pkg::*;
#(
    parameter int            AW      = 22,
    parameter logic [AW-1:0] OFFSET1 = 22'h00_0000,
    parameter logic [AW-1:0] OFFSET2 = 22'h02_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            gfx1_cs,
    input  logic [16:0]     gfx1_addr,
    output logic [15:0]     gfx1_data,
    output logic            gfx1_ok,
    input  logic            gfx2_cs,
    input  logic [16:0]     gfx2_addr,
    output logic [15:0]     gfx2_data,
    output logic            gfx2_ok,
    output logic            sdram_req,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic            sdram_rdy,
    input  logic [15:0]     sdram_din
);

    state_t          st, st_nx;
    logic            req_nx;
    logic [AW-1:0]   addr_nx;
    logic            slot, slot_nx;     // slot being fetched: 0 = gfx1, 1 = gfx2
    logic            last, last_nx;     // slot that won the last contested grant
    logic [ROMW-1:0] faddr, faddr_nx;
    logic            wr;
    logic            grant;
    logic            hit1, hit2;
    logic            miss1, miss2;
    logic [AW-1:0]   ext1, ext2;

    // Offset is added modulo 2^AW; carry out of the top is dropped on purpose
    assign ext1  = OFFSET1 + {{(AW-ROMW){1'b0}}, gfx1_addr};
    assign ext2  = OFFSET2 + {{(AW-ROMW){1'b0}}, gfx2_addr};
    assign miss1 = gfx1_cs & ~hit1;
    assign miss2 = gfx2_cs & ~hit2;

    assign gfx1_ok = hit1;
    assign gfx2_ok = hit2;

    // Arbiter next-state: grant a miss from IDLE, then hold the request until ack and data
    always_comb begin
        st_nx    = st;
        req_nx   = sdram_req;
        addr_nx  = sdram_addr;
        slot_nx  = slot;
        last_nx  = last;
        faddr_nx = faddr;
        wr       = 1'b0;
        grant    = 1'b0;
        case (st)
            IDLE: begin
                if (miss1 | miss2) begin
                    grant = (miss1 & miss2) ? ~last : miss2;
                    if (miss1 & miss2) begin
                        last_nx = grant;
                    end
                    slot_nx  = grant;
                    faddr_nx = grant ? gfx2_addr : gfx1_addr;
                    addr_nx  = grant ? ext2 : ext1;
                    req_nx   = 1'b1;
                    st_nx    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    req_nx = 1'b0;
                    if (sdram_rdy) begin
                        wr    = 1'b1;
                        st_nx = IDLE;
                    end else begin
                        st_nx = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                if (sdram_rdy) begin
                    wr    = 1'b1;
                    st_nx = IDLE;
                end
            end
            default: begin
                st_nx  = IDLE;
                req_nx = 1'b0;
            end
        endcase
    end

    // Arbiter registers; reset abandons any fetch in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            slot       <= 1'b0;
            last       <= 1'b0;
            faddr      <= '0;
        end else begin
            st         <= st_nx;
            sdram_req  <= req_nx;
            sdram_addr <= addr_nx;
            slot       <= slot_nx;
            last       <= last_nx;
            faddr      <= faddr_nx;
        end
    end

    jtcontra_romslot_cache u_cache1 (
        .clk   (clk),
        .clr   (~rst_n),
        .we    (wr & ~slot),
        .waddr (faddr),
        .wdata (sdram_din),
        .cs    (gfx1_cs),
        .addr  (gfx1_addr),
        .hit   (hit1),
        .data  (gfx1_data)
    );

    jtcontra_romslot_cache u_cache2 (
        .clk   (clk),
        .clr   (~rst_n),
        .we    (wr & slot),
        .waddr (faddr),
        .wdata (sdram_din),
        .cs    (gfx2_cs),
        .addr  (gfx2_addr),
        .hit   (hit2),
        .data  (gfx2_data)
    );

endmodule
